// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD controller and its datapath.
//   agr_e   : comparison code reported by the datapath on A_gr
//   sub_e   : subtract command driven to the datapath on sub_AB
//   state_e : controller state
//   W_DEFAULT : default operand/result width
package gcd_pkg;

  localparam int unsigned W_DEFAULT = 10;

  typedef enum logic [1:0] {
    AGR_LOAD = 2'd0,
    AGR_EQ   = 2'd1,
    AGR_GT   = 2'd2,
    AGR_LT   = 2'd3
  } agr_e;

  typedef enum logic [1:0] {
    SUB_NONE = 2'd0,
    SUB_X    = 2'd1,
    SUB_Y    = 2'd2
  } sub_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CMP,
    S_EVAL,
    S_FIN,
    S_CAP,
    S_DONE
  } state_e;

endpackage

// File: rtl/gcd_ctrl_if.sv
// System-side handshake bundle of the GCD controller.
//   req_valid / req_ready : operand request (operands themselves sit on the datapath)
//   out_valid / out_ready : result handshake
//   out_data              : captured GCD
//   out_err               : result aborted
// master = system/requester side, slave = controller side.
interface gcd_ctrl_if #(
  parameter int unsigned W = gcd_pkg::W_DEFAULT
);
  logic         req_valid;
  logic         req_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_err;

  modport master (
    output req_valid, out_ready,
    input  req_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  req_valid, out_ready,
    output req_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/gcd_ctrl.sv
// Control FSM for the subtractive GCD datapath.
// Sequences the datapath through load, compare, subtract and finish,
// then holds the published result until the consumer takes it.
//   clk, rst  : clock, synchronous active-high reset
//   sys       : request/result handshake bundle (slave side)
//   A_gr      : datapath comparison code
//   dp_res    : datapath result (valid for one cycle after finish)
//   start     : datapath load strobe
//   finish    : datapath publish strobe
//   sub_AB    : datapath subtract command
//   iter_cnt  : subtractions performed in the current/last operation
//   busy      : controller not idle
module gcd_ctrl
  import gcd_pkg::*;
#(
  parameter int unsigned W        = W_DEFAULT,
  parameter int unsigned MAX_ITER = 1023,
  parameter int unsigned CW       = $clog2(MAX_ITER + 1)
) (
  input  logic          clk,
  input  logic          rst,
  gcd_ctrl_if.slave     sys,
  input  logic [1:0]    A_gr,
  input  logic [W-1:0]  dp_res,
  output logic          start,
  output logic          finish,
  output logic [1:0]    sub_AB,
  output logic [CW-1:0] iter_cnt,
  output logic          busy
);

  localparam logic [CW-1:0] ITER_LIM = CW'(MAX_ITER);

  state_e       state;
  logic         at_limit;
  logic [W-1:0] data_q;
  logic         err_q;

  assign at_limit = (iter_cnt == ITER_LIM);

  assign sys.req_ready = (state == S_IDLE);
  assign sys.out_valid = (state == S_DONE);
  assign sys.out_data  = data_q;
  assign sys.out_err   = err_q;
  assign start         = (state == S_LOAD);
  assign finish        = (state == S_FIN);
  assign busy          = (state != S_IDLE);

  // The subtract command must act in the same cycle the comparison is seen,
  // so it is the one output decoded from A_gr as well as state. At the
  // iteration limit it is suppressed, which is what makes the abort safe.
  always_comb begin
    sub_AB = SUB_NONE;
    if (state == S_EVAL && !at_limit) begin
      if (A_gr == AGR_GT)      sub_AB = SUB_X;
      else if (A_gr == AGR_LT) sub_AB = SUB_Y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      iter_cnt <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sys.req_valid) begin
            state    <= S_LOAD;
            iter_cnt <= '0;
            err_q    <= 1'b0;
          end
        end
        S_LOAD: state <= S_CMP;
        S_CMP:  state <= S_EVAL;
        S_EVAL: begin
          if (A_gr == AGR_EQ) begin
            state <= S_FIN;
          end else if (A_gr == AGR_GT || A_gr == AGR_LT) begin
            if (at_limit) begin
              // Limit reached (e.g. a zero operand): abort, counter stays saturated.
              err_q <= 1'b1;
              state <= S_FIN;
            end else begin
              iter_cnt <= iter_cnt + CW'(1);
              state    <= S_CMP;
            end
          end else begin
            // AGR_LOAD after a compare cycle means the datapath misbehaved.
            err_q <= 1'b1;
            state <= S_FIN;
          end
        end
        S_FIN: state <= S_CAP;
        S_CAP: begin
          data_q <= dp_res;
          state  <= S_DONE;
        end
        S_DONE: begin
          if (sys.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_ctrl.sv
// Self-checking bench for gcd_ctrl with a behavioural subtractive datapath attached.
module tb_gcd_ctrl;
  import gcd_pkg::*;

  localparam int unsigned W        = 10;
  localparam int unsigned MAX_ITER = 1023;
  localparam int unsigned CW       = $clog2(MAX_ITER + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    A_gr;
  logic [W-1:0]  dp_res;
  logic          start, finish;
  logic [1:0]    sub_AB;
  logic [CW-1:0] iter_cnt;
  logic          busy;

  gcd_ctrl_if #(.W(W)) sys_if ();

  gcd_ctrl #(.W(W), .MAX_ITER(MAX_ITER), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .sys      (sys_if),
    .A_gr     (A_gr),
    .dp_res   (dp_res),
    .start    (start),
    .finish   (finish),
    .sub_AB   (sub_AB),
    .iter_cnt (iter_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: x/y registers, compare code refreshed every edge
  // that is not a load, result registered on finish.
  logic [W-1:0] op_a, op_b, x, y;
  logic [1:0]   agr_r;
  bit           force_agr0 = 1'b0;

  always @(posedge clk) begin
    if (start) begin
      x     <= op_a;
      y     <= op_b;
      agr_r <= 2'd0;
    end else begin
      if (sub_AB == 2'd1)      x <= x - y;
      else if (sub_AB == 2'd2) y <= y - x;
      agr_r <= (x == y) ? 2'd1 : (x > y) ? 2'd2 : 2'd3;
    end
    if (finish) dp_res <= x;
  end
  assign A_gr = force_agr0 ? 2'd0 : agr_r;

  // Activity monitor
  logic [1:0] subq[$];
  int fin_pulses = 0;
  int both_hi    = 0;
  int sub3       = 0;
  always @(posedge clk) begin
    if (!rst) begin
      if (sub_AB != 2'd0) subq.push_back(sub_AB);
      if (finish) fin_pulses++;
      if (sys_if.out_valid && sys_if.req_ready) both_hi++;
      if (sub_AB == 2'd3) sub3++;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference: subtractive GCD step count equals the sum of Euclid quotients minus one.
  function automatic void ref_gcd(input int a, input int b, output int g, output bit e, output int s);
    int p, q, t;
    p = a; q = b; e = 1'b0; s = 0; g = 0;
    if (a == b) begin g = a; return; end
    if (a == 0 || b == 0) begin e = 1'b1; s = MAX_ITER; return; end
    while (q != 0) begin
      s += p / q;
      t = p % q;
      p = q;
      q = t;
    end
    g = p;
    s -= 1;
    if (s > int'(MAX_ITER)) begin e = 1'b1; s = MAX_ITER; end
  endfunction

  task automatic do_op(input string tag, input int a, input int b, input int hold,
                       output int d, output bit e, output int it, output int cyc);
    int held;
    op_a = W'(a);
    op_b = W'(b);
    sys_if.req_valid = 1'b1;
    @(posedge clk); #1;
    sys_if.req_valid = 1'b0;
    cyc = 1;
    while (!sys_if.out_valid && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!sys_if.out_valid) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: got no out_valid after %0d cycles, expected out_valid", tag, cyc);
    end
    d   = int'(sys_if.out_data);
    e   = sys_if.out_err;
    it  = int'(iter_cnt);
    check({tag, "_req_ready_in_done"}, sys_if.req_ready, 1'b0);
    held = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (sys_if.out_valid !== 1'b1 || int'(sys_if.out_data) != d || sys_if.req_ready !== 1'b0) held++;
    end
    if (hold > 0) check({tag, "_hold_unstable_cycles"}, held, 0);
    sys_if.out_ready = 1'b1;
    @(posedge clk); #1;
    sys_if.out_ready = 1'b0;
    check({tag, "_idle_after_ack"}, sys_if.req_ready, 1'b1);
    check({tag, "_valid_dropped"}, sys_if.out_valid, 1'b0);
    check({tag, "_iter_held_in_idle"}, iter_cnt, it);
  endtask

  typedef struct {
    string name;
    int    a;
    int    b;
    int    g;
    bit    e;
    int    s;
    int    hold;
  } vec_t;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[$];
    int d, it, cyc, g, s, f0;
    bit e, re;

    vecs.push_back('{"gcd_12_18",  12,   18,   6, 1'b0,    2,  0});
    vecs.push_back('{"gcd_1_1023", 1,    1023, 1, 1'b0, 1022,  0});
    vecs.push_back('{"gcd_0_5",    0,    5,    0, 1'b1, 1023,  0});
    vecs.push_back('{"gcd_7_7",    7,    7,    7, 1'b0,    0, 20});
    vecs.push_back('{"gcd_1023_1", 1023, 1,    1, 1'b0, 1022,  0});
    vecs.push_back('{"gcd_0_0",    0,    0,    0, 1'b0,    0,  0});

    rst = 1'b1;
    sys_if.req_valid = 1'b0;
    sys_if.out_ready = 1'b0;
    op_a = '0;
    op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", sys_if.req_ready, 1'b1);
    check("rst_busy",      busy, 1'b0);
    check("rst_start",     start, 1'b0);
    check("rst_finish",    finish, 1'b0);
    check("rst_sub_AB",    sub_AB, 2'd0);
    check("rst_out_valid", sys_if.out_valid, 1'b0);
    check("rst_out_data",  sys_if.out_data, 0);
    check("rst_out_err",   sys_if.out_err, 1'b0);
    check("rst_iter_cnt",  iter_cnt, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[k]) begin
      subq.delete();
      do_op(vecs[k].name, vecs[k].a, vecs[k].b, vecs[k].hold, d, e, it, cyc);
      if (!vecs[k].e) check({vecs[k].name, "_data"}, d, vecs[k].g);
      check({vecs[k].name, "_err"},     e, vecs[k].e);
      check({vecs[k].name, "_iter"},    it, vecs[k].s);
      check({vecs[k].name, "_latency"}, cyc, 2 * vecs[k].s + 6);
      if (k == 0) begin
        check("gcd_12_18_sub_count", subq.size(), 2);
        if (subq.size() == 2) begin
          check("gcd_12_18_sub0", subq[0], 2'd2);
          check("gcd_12_18_sub1", subq[1], 2'd1);
        end
      end
    end

    // Random operands against the arithmetic reference
    for (int n = 0; n < 10; n++) begin
      int a, b;
      a = (n < 2) ? 0 : $urandom_range(1, 1023);
      b = $urandom_range(1, 1023);
      if (n == 1) begin a = b; end
      ref_gcd(a, b, g, re, s);
      do_op("rand", a, b, 0, d, e, it, cyc);
      if (!re) check("rand_data", d, g);
      check("rand_err",     e, re);
      check("rand_iter",    it, s);
      check("rand_latency", cyc, 2 * s + 6);
    end

    // Reset while in CMP abandons the job
    f0 = fin_pulses;
    op_a = W'(100);
    op_b = W'(75);
    sys_if.req_valid = 1'b1;
    @(posedge clk); #1;
    sys_if.req_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_cmp_busy", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_req_ready", sys_if.req_ready, 1'b1);
    check("midrst_busy",      busy, 1'b0);
    check("midrst_start",     start, 1'b0);
    check("midrst_finish",    finish, 1'b0);
    check("midrst_sub_AB",    sub_AB, 2'd0);
    check("midrst_out_valid", sys_if.out_valid, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("midrst_still_idle",  sys_if.out_valid, 1'b0);
    check("midrst_no_finish",   fin_pulses, f0);
    do_op("after_rst", 100, 75, 0, d, e, it, cyc);
    check("after_rst_data", d, 25);
    check("after_rst_err",  e, 1'b0);
    check("after_rst_iter", it, 3);

    // Datapath reporting "just loaded" during evaluation
    force_agr0 = 1'b1;
    f0 = fin_pulses;
    do_op("agr0", 9, 4, 0, d, e, it, cyc);
    force_agr0 = 1'b0;
    check("agr0_err",        e, 1'b1);
    check("agr0_fin_pulses", fin_pulses - f0, 1);
    check("agr0_latency",    cyc, 6);
    check("agr0_iter",       it, 0);

    // Next job clears the error flag
    do_op("post_agr0", 21, 14, 0, d, e, it, cyc);
    check("post_agr0_data", d, 7);
    check("post_agr0_err",  e, 1'b0);

    check("never_valid_and_ready", both_hi, 0);
    check("never_sub3",            sub3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
